// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - round-robin sequencer driving one-hot oe/we for register-to-register bus moves
module bus_xfer_ctrl #(
  parameter int p_num_regs  = 4,
  parameter int p_sel_width = 2
) (
  input  logic                   i_w_clk,
  input  logic                   i_w_reset,
  input  logic                   i_w_req_a,
  input  logic [p_sel_width-1:0] i_w_src_a,
  input  logic [p_sel_width-1:0] i_w_dst_a,
  output logic                   o_w_gnt_a,
  input  logic                   i_w_req_b,
  input  logic [p_sel_width-1:0] i_w_src_b,
  input  logic [p_sel_width-1:0] i_w_dst_b,
  output logic                   o_w_gnt_b,
  output logic [p_num_regs-1:0]  o_w_oe,
  output logic [p_num_regs-1:0]  o_w_we,
  output logic                   o_w_busy,
  output logic                   o_w_done,
  output logic                   o_w_err,
  output logic                   o_w_owner
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WRITE, S_DONE, S_ERR} state_t;

  state_t                 state_q, state_d;
  logic                   prio_b_q, prio_b_d;
  logic                   owner_q, owner_d;
  logic [p_sel_width-1:0] src_q, src_d, dst_q, dst_d;
  logic [p_num_regs-1:0]  oe_q, oe_d, we_q, we_d;
  logic                   done_q, done_d, err_q, err_d;
  logic                   gnt_a, gnt_b, legal;
  logic [p_sel_width-1:0] sel_src, sel_dst;

  always_comb begin
    state_d  = state_q;
    prio_b_d = prio_b_q;
    owner_d  = owner_q;
    src_d    = src_q;
    dst_d    = dst_q;
    oe_d     = '0;
    we_d     = '0;

    gnt_a   = (state_q == S_IDLE) && i_w_req_a && (!i_w_req_b || !prio_b_q);
    gnt_b   = (state_q == S_IDLE) && i_w_req_b && (!i_w_req_a || prio_b_q);
    sel_src = gnt_b ? i_w_src_b : i_w_src_a;
    sel_dst = gnt_b ? i_w_dst_b : i_w_dst_a;
    legal   = (sel_src != sel_dst) && (32'(sel_src) < p_num_regs) &&
              (32'(sel_dst) < p_num_regs);

    case (state_q)
      S_IDLE: begin
        if (gnt_a || gnt_b) begin
          src_d    = sel_src;
          dst_d    = sel_dst;
          owner_d  = gnt_b;
          // Winner loses priority so a held competitor goes next.
          prio_b_d = gnt_a;
          state_d  = legal ? S_DRIVE : S_ERR;
        end
      end
      S_DRIVE: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they launch from flops.
    for (int i = 0; i < p_num_regs; i++) begin
      oe_d[i] = ((state_d == S_DRIVE) || (state_d == S_WRITE)) &&
                (src_d == p_sel_width'(i));
      we_d[i] = (state_d == S_WRITE) && (dst_d == p_sel_width'(i));
    end
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q  <= S_IDLE;
      prio_b_q <= 1'b0;
      owner_q  <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      oe_q     <= '0;
      we_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_b_q <= prio_b_d;
      owner_q  <= owner_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_w_gnt_a = gnt_a;
  assign o_w_gnt_b = gnt_b;
  assign o_w_oe    = oe_q;
  assign o_w_we    = we_q;
  assign o_w_busy  = (state_q != S_IDLE);
  assign o_w_done  = done_q;
  assign o_w_err   = err_q;
  assign o_w_owner = owner_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 0, req_b = 0;
  logic [1:0] src_a = 0, dst_a = 0, src_b = 0, dst_b = 0;
  logic       gnt_a, gnt_b, busy, done, err, owner;
  logic [3:0] oe, we;

  logic       r3_req_a = 0, r3_req_b = 0;
  logic [1:0] r3_src_a = 0, r3_dst_a = 0, r3_src_b = 0, r3_dst_b = 0;
  logic       g3_a, g3_b, busy3, done3, err3, owner3;
  logic [2:0] oe3, we3;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] bus_regs [4];
  logic       bus_load = 1'b0;
  logic [7:0] bus_val;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.p_num_regs(4), .p_sel_width(2)) u_dut (
    .i_w_clk(clk), .i_w_reset(rst),
    .i_w_req_a(req_a), .i_w_src_a(src_a), .i_w_dst_a(dst_a), .o_w_gnt_a(gnt_a),
    .i_w_req_b(req_b), .i_w_src_b(src_b), .i_w_dst_b(dst_b), .o_w_gnt_b(gnt_b),
    .o_w_oe(oe), .o_w_we(we), .o_w_busy(busy), .o_w_done(done),
    .o_w_err(err), .o_w_owner(owner)
  );

  bus_xfer_ctrl #(.p_num_regs(3), .p_sel_width(2)) u_dut3 (
    .i_w_clk(clk), .i_w_reset(rst),
    .i_w_req_a(r3_req_a), .i_w_src_a(r3_src_a), .i_w_dst_a(r3_dst_a), .o_w_gnt_a(g3_a),
    .i_w_req_b(r3_req_b), .i_w_src_b(r3_src_b), .i_w_dst_b(r3_dst_b), .o_w_gnt_b(g3_b),
    .o_w_oe(oe3), .o_w_we(we3), .o_w_busy(busy3), .o_w_done(done3),
    .o_w_err(err3), .o_w_owner(owner3)
  );

  // Bus model: registers on a shared bus, driven by oe and captured by we.
  always_comb begin
    bus_val = 8'h00;
    for (int i = 0; i < 4; i++) if (oe[i]) bus_val = bus_val | bus_regs[i];
  end

  always @(posedge clk) begin
    if (bus_load) begin
      bus_regs[0] <= 8'hA0;
      bus_regs[1] <= 8'hB1;
      bus_regs[2] <= 8'hC2;
      bus_regs[3] <= 8'hD3;
    end else begin
      for (int i = 0; i < 4; i++) if (we[i]) bus_regs[i] <= bus_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Structural safety on every cycle: at most one driver, never oe and we together.
  always @(negedge clk) begin
    if (!rst) begin
      check("oe_onehot0", 32'($countones(oe) <= 1), 32'd1);
      check("oe_we_excl", 32'(oe & we), 32'd0);
      check("gnt_excl", 32'(gnt_a & gnt_b), 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_oe", 32'(oe), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_busy3", 32'(busy3), 32'h0);
    rst = 1'b0;

    // A moves 1 -> 3
    step();
    req_a = 1; src_a = 2'd1; dst_a = 2'd3;
    #1 check("t1_gnt_a", 32'(gnt_a), 32'd1);
    check("t1_gnt_b", 32'(gnt_b), 32'd0);
    step(); req_a = 0; src_a = 2'd0; dst_a = 2'd0;
    check("t1_drive_oe", 32'(oe), 32'h2);
    check("t1_drive_we", 32'(we), 32'h0);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t1_write_oe", 32'(oe), 32'h2);
    check("t1_write_we", 32'(we), 32'h8);
    step();
    check("t1_done_oe", 32'(oe), 32'h0);
    check("t1_done_we", 32'(we), 32'h0);
    check("t1_done", 32'(done), 32'd1);
    step();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_done", 32'(done), 32'd0);

    // A (0->1) and B (2->3) together; last winner was A but B idle, so re-test from reset state of arbiter
    rst = 1'b1; #1 rst = 1'b0;
    req_a = 1; src_a = 2'd0; dst_a = 2'd1;
    req_b = 1; src_b = 2'd2; dst_b = 2'd3;
    #1 check("t2_gnt_a1", 32'(gnt_a), 32'd1);
    check("t2_gnt_b1", 32'(gnt_b), 32'd0);
    step(); req_a = 0;
    check("t2_owner1", 32'(owner), 32'd0);
    check("t2_busy_gnt_b", 32'(gnt_b), 32'd0);
    check("t2_oe_a", 32'(oe), 32'h1);
    repeat (3) step();
    req_a = 1;
    #1 check("t2_gnt_b2", 32'(gnt_b), 32'd1);
    check("t2_gnt_a2", 32'(gnt_a), 32'd0);
    step(); req_b = 0;
    check("t2_owner2", 32'(owner), 32'd1);
    check("t2_oe_b", 32'(oe), 32'h4);
    repeat (3) step();
    check("t2_gnt_a3", 32'(gnt_a), 32'd1);
    step(); req_a = 0;
    check("t2_owner3", 32'(owner), 32'd0);
    repeat (3) step();

    // Illegal src == dst
    req_a = 1; src_a = 2'd2; dst_a = 2'd2;
    #1 check("t3_gnt_a", 32'(gnt_a), 32'd1);
    step(); req_a = 0;
    check("t3_err", 32'(err), 32'd1);
    check("t3_oe", 32'(oe), 32'h0);
    check("t3_we", 32'(we), 32'h0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    step();
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_busy_clr", 32'(busy), 32'd0);
    check("t3_no_done", 32'(done), 32'd0);

    // Back-to-back A: 0->1 then 1->2 with bus model
    bus_load = 1; step(); bus_load = 0;
    req_a = 1; src_a = 2'd0; dst_a = 2'd1;
    #1 check("t6_gnt1", 32'(gnt_a), 32'd1);
    step(); src_a = 2'd1; dst_a = 2'd2;
    check("t6_gnt_busy1", 32'(gnt_a), 32'd0);
    step(); check("t6_gnt_busy2", 32'(gnt_a), 32'd0);
    step(); check("t6_gnt_busy3", 32'(gnt_a), 32'd0);
    step(); check("t6_gnt2", 32'(gnt_a), 32'd1);
    check("t6_reg1", 32'(bus_regs[1]), 32'hA0);
    step(); req_a = 0;
    repeat (3) step();
    check("t6_reg2", 32'(bus_regs[2]), 32'hA0);
    check("t6_reg0", 32'(bus_regs[0]), 32'hA0);
    check("t6_reg3", 32'(bus_regs[3]), 32'hD3);

    // p_num_regs=3: B dst=3 is out of range
    r3_req_b = 1; r3_src_b = 2'd0; r3_dst_b = 2'd3;
    #1 check("t4_gnt_b", 32'(g3_b), 32'd1);
    step(); r3_req_b = 0;
    check("t4_err", 32'(err3), 32'd1);
    check("t4_oe", 32'(oe3), 32'h0);
    check("t4_we", 32'(we3), 32'h0);
    step();
    check("t4_idle", 32'(busy3), 32'd0);
    r3_req_b = 1; r3_src_b = 2'd0; r3_dst_b = 2'd2;
    #1 check("t4_gnt_b2", 32'(g3_b), 32'd1);
    step(); r3_req_b = 0;
    check("t4_oe2", 32'(oe3), 32'h1);
    check("t4_owner", 32'(owner3), 32'd1);
    step();
    check("t4_we2", 32'(we3), 32'h4);
    step();
    check("t4_done", 32'(done3), 32'd1);
    step();

    // Reset during WRITE
    req_a = 1; src_a = 2'd0; dst_a = 2'd1;
    #1 check("t5_gnt", 32'(gnt_a), 32'd1);
    step(); req_a = 0;
    step();
    check("t5_we_write", 32'(we), 32'h2);
    #2 rst = 1'b1;
    #1 check("t5_oe_rst", 32'(oe), 32'h0);
    check("t5_we_rst", 32'(we), 32'h0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    step();
    check("t5_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    req_a = 1; req_b = 1; src_a = 2'd1; dst_a = 2'd0; src_b = 2'd2; dst_b = 2'd3;
    #1 check("t5_gnt_a", 32'(gnt_a), 32'd1);
    check("t5_gnt_b", 32'(gnt_b), 32'd0);
    step(); req_a = 0; req_b = 0;
    check("t5_owner", 32'(owner), 32'd0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
